// File: rtl/mc_control32.sv
// mc_control32: multi-cycle sequencer for the minisys 32-bit MIPS-subset datapath.
// Steps the shared ALU, register file and single memory port through
// IF/ID/EX/MEM/WB, with a watchdog on the memory request/ready handshake.
// Control outputs are decoded combinationally from the state register and
// are forced low while reset is asserted.
module mc_control32 #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Function_opcode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic [1:0] RegDST,
    output logic       MemtoReg,
    output logic       Sftmd,
    output logic [2:0] state,
    output logic       instr_done,
    output logic       error
);

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4,
        ST_ERR = 3'd5
    } state_t;

    // Counter value seen in the last tolerated wait cycle; one more miss trips ERR.
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic is_r_s, is_jr_s, is_shift_s, is_lw_s, is_sw_s, is_beq_s, is_bne_s;
    logic is_j_s, is_jal_s, is_iarith_s, is_legal_s;

    logic       mem_req_s, iord_s, memread_s, memwrite_s, irwrite_s, pcwrite_s;
    logic [1:0] pcsrc_s, alusrcb_s, aluop_s, regdst_s;
    logic       alusrca_s, regwrite_s, memtoreg_s, sftmd_s, done_s, error_s;

    // Instruction class decode from the IR fields.
    always_comb begin
        is_r_s      = (Opcode == 6'b000000);
        is_jr_s     = is_r_s && (Function_opcode == 6'b001000);
        is_shift_s  = is_r_s && (Function_opcode[5:3] == 3'b000);
        is_lw_s     = (Opcode == 6'b100011);
        is_sw_s     = (Opcode == 6'b101011);
        is_beq_s    = (Opcode == 6'b000100);
        is_bne_s    = (Opcode == 6'b000101);
        is_j_s      = (Opcode == 6'b000010);
        is_jal_s    = (Opcode == 6'b000011);
        is_iarith_s = (Opcode[5:3] == 3'b001);
        is_legal_s  = is_r_s | is_lw_s | is_sw_s | is_beq_s | is_bne_s |
                      is_j_s | is_jal_s | is_iarith_s;
    end

    // Next-state and raw control decode for the current state.
    always_comb begin
        state_d    = state_q;
        mem_req_s  = 1'b0;
        iord_s     = 1'b0;
        memread_s  = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        pcwrite_s  = 1'b0;
        pcsrc_s    = 2'b00;
        alusrca_s  = 1'b0;
        alusrcb_s  = 2'b00;
        aluop_s    = 2'b00;
        regwrite_s = 1'b0;
        regdst_s   = 2'b00;
        memtoreg_s = 1'b0;
        sftmd_s    = 1'b0;
        done_s     = 1'b0;
        error_s    = 1'b0;
        case (state_q)
            ST_IF: begin
                mem_req_s = 1'b1;
                memread_s = 1'b1;
                alusrcb_s = 2'b01;
                if (mem_ready) begin
                    irwrite_s = 1'b1;
                    pcwrite_s = 1'b1;
                    state_d   = ST_ID;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_IF;
                end
            end
            ST_ID: begin
                alusrcb_s = 2'b11;
                if (is_j_s) begin
                    pcwrite_s = 1'b1;
                    pcsrc_s   = 2'b10;
                    done_s    = 1'b1;
                    state_d   = ST_IF;
                end else if (is_jal_s) begin
                    pcwrite_s = 1'b1;
                    pcsrc_s   = 2'b10;
                    state_d   = ST_WB;
                end else if (is_jr_s) begin
                    pcwrite_s = 1'b1;
                    pcsrc_s   = 2'b11;
                    done_s    = 1'b1;
                    state_d   = ST_IF;
                end else if (!is_legal_s) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_EX;
                end
            end
            ST_EX: begin
                alusrca_s = 1'b1;
                if (is_r_s) begin
                    aluop_s = 2'b10;
                    sftmd_s = is_shift_s;
                    state_d = ST_WB;
                end else if (is_iarith_s) begin
                    alusrcb_s = 2'b10;
                    aluop_s   = 2'b10;
                    state_d   = ST_WB;
                end else if (is_lw_s || is_sw_s) begin
                    alusrcb_s = 2'b10;
                    state_d   = ST_MEM;
                end else if (is_beq_s || is_bne_s) begin
                    aluop_s   = 2'b01;
                    pcsrc_s   = 2'b01;
                    pcwrite_s = is_beq_s ? Zero : !Zero;
                    done_s    = 1'b1;
                    state_d   = ST_IF;
                end else begin
                    state_d = ST_ERR;
                end
            end
            ST_MEM: begin
                mem_req_s  = 1'b1;
                iord_s     = 1'b1;
                memread_s  = is_lw_s;
                memwrite_s = is_sw_s;
                if (mem_ready) begin
                    if (is_lw_s) begin
                        state_d = ST_WB;
                    end else if (is_sw_s) begin
                        done_s  = 1'b1;
                        state_d = ST_IF;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                regwrite_s = 1'b1;
                regdst_s   = is_r_s ? 2'b01 : (is_jal_s ? 2'b10 : 2'b00);
                memtoreg_s = is_lw_s;
                done_s     = 1'b1;
                state_d    = ST_IF;
            end
            ST_ERR: begin
                error_s = 1'b1;
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase
    end

    // Memory wait counter: restarts on a new access or on ready, counts stalled cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (mem_ready) begin
            cnt_d = {CNT_W{1'b0}};
        end else if ((state_d != state_q) && ((state_d == ST_IF) || (state_d == ST_MEM))) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (mem_req_s) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State register and wait counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IF;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Force every output low while reset is held so no strobe survives an abort.
    always_comb begin
        if (!reset) begin
            mem_req    = 1'b0;
            IorD       = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            PCSrc      = 2'b00;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            ALUOp      = 2'b00;
            RegWrite   = 1'b0;
            RegDST     = 2'b00;
            MemtoReg   = 1'b0;
            Sftmd      = 1'b0;
            state      = 3'd0;
            instr_done = 1'b0;
            error      = 1'b0;
        end else begin
            mem_req    = mem_req_s;
            IorD       = iord_s;
            MemRead    = memread_s;
            MemWrite   = memwrite_s;
            IRWrite    = irwrite_s;
            PCWrite    = pcwrite_s;
            PCSrc      = pcsrc_s;
            ALUSrcA    = alusrca_s;
            ALUSrcB    = alusrcb_s;
            ALUOp      = aluop_s;
            RegWrite   = regwrite_s;
            RegDST     = regdst_s;
            MemtoReg   = memtoreg_s;
            Sftmd      = sftmd_s;
            state      = state_q;
            instr_done = done_s;
            error      = error_s;
        end
    end

endmodule

// File: tb/tb_mc_control32.sv
// Testbench for mc_control32: table of instructions with expected latency and
// final-cycle controls, checked through a scoreboard queue, plus hand-written
// sequences for reset, illegal opcode, memory timeout and reset during a store.
module tb_mc_control32;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] Opcode, Function_opcode;
    logic       Zero, mem_ready;
    logic       mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite;
    logic [1:0] PCSrc, ALUSrcB, ALUOp, RegDST;
    logic       ALUSrcA, RegWrite, MemtoReg, Sftmd, instr_done, error;
    logic [2:0] state;

    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    mc_control32 #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .Opcode(Opcode), .Function_opcode(Function_opcode),
        .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .RegWrite(RegWrite), .RegDST(RegDST), .MemtoReg(MemtoReg), .Sftmd(Sftmd),
        .state(state), .instr_done(instr_done), .error(error)
    );

    // fin = {PCWrite, PCSrc, RegWrite, RegDST, MemtoReg} in the retiring cycle
    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       zero;
        int         if_w;
        int         mem_w;
        int         cycles;
        logic [2:0] fin_state;
        logic [2:0] id_pc;
        logic [6:0] fin;
        logic       sft;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [22:0] obs_all();
        return {mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA,
                ALUSrcB, ALUOp, RegWrite, RegDST, MemtoReg, Sftmd, state, instr_done, error};
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Drive one instruction with a simple memory model and score its retirement.
    task automatic run_instr(input vec_t v);
        int         cyc = 0;
        int         wcnt = 0;
        logic [2:0] prev = 3'd7;
        logic [2:0] id_obs = 3'd0;
        logic [2:0] fst = 3'd7;
        logic [6:0] fin = 7'd0;
        logic       sft = 1'b0;
        logic       hold_bad = 1'b0;
        logic       done = 1'b0;
        vec_t       e;
        Opcode = v.op;
        Function_opcode = v.fn;
        Zero = v.zero;
        sb_q.push_back(v);
        while (!done && cyc < 60) begin
            if (state != prev) wcnt = 0;
            prev = state;
            if (state == 3'd0) mem_ready = (wcnt >= v.if_w);
            else if (state == 3'd3) mem_ready = (wcnt >= v.mem_w);
            else mem_ready = 1'($urandom_range(0, 1));
            wcnt++;
            #1;
            cyc++;
            if (state == 3'd1) id_obs = {PCWrite, PCSrc};
            if (Sftmd) sft = 1'b1;
            if (mem_req && !(MemRead || MemWrite)) hold_bad = 1'b1;
            if (instr_done || error) begin
                done = 1'b1;
                fst = state;
                fin = {PCWrite, PCSrc, RegWrite, RegDST, MemtoReg};
            end
            @(posedge clock);
            @(negedge clock);
        end
        e = sb_q.pop_front();
        check($sformatf("%s.cycles", e.name), 32'(cyc), 32'(e.cycles));
        check($sformatf("%s.fin_state", e.name), 32'(fst), 32'(e.fin_state));
        check($sformatf("%s.fin_ctrl", e.name), 32'(fin), 32'(e.fin));
        check($sformatf("%s.id_pc", e.name), 32'(id_obs), 32'(e.id_pc));
        check($sformatf("%s.sftmd", e.name), 32'(sft), 32'(e.sft));
        check($sformatf("%s.strobe_hold", e.name), 32'(hold_bad), 32'd0);
    endtask

    initial begin
        int n_if;
        logic bad;
        vec_t add_v;

        //            name     op         fn         z     ifw mw cyc fst   id      fin          sft
        vecs.push_back('{"add",   6'h00, 6'b100000, 1'b0, 0, 0, 4,  3'd4, 3'b000, 7'b0_00_1_01_0, 1'b0});
        vecs.push_back('{"sll",   6'h00, 6'b000000, 1'b0, 0, 0, 4,  3'd4, 3'b000, 7'b0_00_1_01_0, 1'b1});
        vecs.push_back('{"srlv",  6'h00, 6'b000110, 1'b0, 0, 0, 4,  3'd4, 3'b000, 7'b0_00_1_01_0, 1'b1});
        vecs.push_back('{"addi",  6'h08, 6'b000000, 1'b0, 0, 0, 4,  3'd4, 3'b000, 7'b0_00_1_00_0, 1'b0});
        vecs.push_back('{"lw33",  6'h23, 6'b001000, 1'b0, 3, 3, 11, 3'd4, 3'b000, 7'b0_00_1_00_1, 1'b0});
        vecs.push_back('{"lw",    6'h23, 6'b000000, 1'b0, 0, 0, 5,  3'd4, 3'b000, 7'b0_00_1_00_1, 1'b0});
        vecs.push_back('{"sw",    6'h2b, 6'b000000, 1'b0, 0, 0, 4,  3'd3, 3'b000, 7'b0_00_0_00_0, 1'b0});
        vecs.push_back('{"sw12",  6'h2b, 6'b000000, 1'b0, 1, 2, 7,  3'd3, 3'b000, 7'b0_00_0_00_0, 1'b0});
        vecs.push_back('{"beq_z1",6'h04, 6'b000000, 1'b1, 0, 0, 3,  3'd2, 3'b000, 7'b1_01_0_00_0, 1'b0});
        vecs.push_back('{"beq_z0",6'h04, 6'b000000, 1'b0, 0, 0, 3,  3'd2, 3'b000, 7'b0_01_0_00_0, 1'b0});
        vecs.push_back('{"bne_z0",6'h05, 6'b000000, 1'b0, 0, 0, 3,  3'd2, 3'b000, 7'b1_01_0_00_0, 1'b0});
        vecs.push_back('{"bne_z1",6'h05, 6'b000000, 1'b1, 0, 0, 3,  3'd2, 3'b000, 7'b0_01_0_00_0, 1'b0});
        vecs.push_back('{"j",     6'h02, 6'b000000, 1'b0, 0, 0, 2,  3'd1, 3'b110, 7'b1_10_0_00_0, 1'b0});
        vecs.push_back('{"jal",   6'h03, 6'b000000, 1'b0, 0, 0, 3,  3'd4, 3'b110, 7'b0_00_1_10_0, 1'b0});
        vecs.push_back('{"jr",    6'h00, 6'b001000, 1'b0, 0, 0, 2,  3'd1, 3'b111, 7'b1_11_0_00_0, 1'b0});
        vecs.push_back('{"add_w2",6'h00, 6'b100000, 1'b0, 2, 0, 6,  3'd4, 3'b000, 7'b0_00_1_01_0, 1'b0});
        add_v = vecs[0];

        // Reset: everything low even with mem_ready high
        reset = 1'b0;
        mem_ready = 1'b1;
        Opcode = 6'h00;
        Function_opcode = 6'h20;
        Zero = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("reset_outs", 32'(obs_all()), 32'd0);
        reset = 1'b1;

        foreach (vecs[i]) run_instr(vecs[i]);

        // Illegal opcode: IF, ID, then sticky ERR
        do_reset();
        Opcode = 6'h3f;
        mem_ready = 1'b1;
        #1;
        check("illegal.s0", 32'(state), 32'd0);
        @(posedge clock); @(negedge clock); #1;
        check("illegal.s1", 32'(state), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); @(negedge clock); #1;
            check($sformatf("illegal.err%0d", k), 32'(obs_all()), 32'h15);
        end

        // Fetch timeout with ready held low
        do_reset();
        Opcode = 6'h00;
        Function_opcode = 6'h20;
        mem_ready = 1'b0;
        n_if = 0;
        bad = 1'b0;
        #1;
        while (state == 3'd0 && n_if < 20) begin
            n_if++;
            if (IRWrite || PCWrite) bad = 1'b1;
            @(posedge clock); @(negedge clock); #1;
        end
        check("timeout.if_cycles", 32'(n_if), 32'd4);
        check("timeout.no_update", 32'(bad), 32'd0);
        check("timeout.state", 32'(state), 32'd5);
        check("timeout.error", 32'(error), 32'd1);

        // Store aborted by reset while waiting in MEM
        do_reset();
        Opcode = 6'h2b;
        Function_opcode = 6'h00;
        mem_ready = 1'b1;
        @(posedge clock); @(negedge clock);
        mem_ready = 1'b0;
        repeat (3) begin @(posedge clock); @(negedge clock); end
        #1;
        check("sw_abort.state", 32'(state), 32'd3);
        check("sw_abort.memwrite", 32'(MemWrite), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("sw_abort.drop", 32'(obs_all()), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        add_v.name = "add_after_abort";
        run_instr(add_v);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
